// File: rtl/slave_port_pkg.sv
// Shared definitions for the serial slave port: FSM states, transfer mode encoding
// and small elaboration-time helpers.
package slave_port_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWdata,
        StWrite,
        StRreq,
        StRwait,
        StRdata
    } state_e;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/slave_port_rx_shift.sv
// Serial-to-parallel field receiver: shifts in len_i bits LSB first, flags the final
// bit with done_o and presents the right-aligned field in that same cycle.
module serial_rx_shift #(
    parameter int unsigned Width = 12,
    parameter int unsigned CntW  = $clog2(Width + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             shift_en_i,
    input  logic             bit_i,
    input  logic [CntW-1:0]  len_i,
    output logic [Width-1:0] field_o,
    output logic             done_o
);

    logic [Width-1:0] data_q, data_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [Width-1:0] shifted;

    always_comb begin
        shifted            = data_q >> 1;
        shifted[Width-1]   = bit_i;
        // Fields shorter than Width sit in the top bits after len_i shifts.
        field_o            = shifted >> (CntW'(Width) - len_i);
        done_o             = shift_en_i && (cnt_q == len_i - CntW'(1));
        data_d             = data_q;
        cnt_d              = cnt_q;
        if (shift_en_i) begin
            if (done_o) begin
                data_d = '0;
                cnt_d  = '0;
            end else begin
                data_d = shifted;
                cnt_d  = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/slave_port.sv
// Slave side of the serial bus: collects address/mode/write data, drives a single-port
// memory with 1-cycle read latency and serialises read data back LSB first.
module slave_port
    import slave_port_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  swdata,
    input  logic                  smode,
    input  logic                  mvalid,
    output logic                  srdata,
    output logic                  svalid,
    output logic                  sready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned FieldW = max_u(ADDR_WIDTH, DATA_WIDTH);
    localparam int unsigned CntW   = $clog2(FieldW + 1);
    localparam int unsigned TxCntW = $clog2(DATA_WIDTH + 1);

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic                  sready_q, sready_d;
    logic                  svalid_q, svalid_d;
    logic                  srdata_q, srdata_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_wen_q, mem_wen_d;
    logic                  mem_ren_q, mem_ren_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [TxCntW-1:0]     tx_cnt_q, tx_cnt_d;

    logic                  rx_shift_en;
    logic [CntW-1:0]       rx_len;
    logic [FieldW-1:0]     rx_field;
    logic                  rx_done;
    logic                  mode_eff;

    // The receiver is shared: address field first, then (for writes) the data field.
    assign rx_shift_en = mvalid &&
                         (state_q == StIdle || state_q == StAddr || state_q == StWdata);
    assign rx_len      = (state_q == StWdata) ? CntW'(DATA_WIDTH) : CntW'(ADDR_WIDTH);
    assign mode_eff    = (state_q == StIdle) ? smode : mode_q;

    serial_rx_shift #(
        .Width (FieldW),
        .CntW  (CntW)
    ) u_rx (
        .clk_i      (clk),
        .rst_i      (rstn),
        .shift_en_i (rx_shift_en),
        .bit_i      (swdata),
        .len_i      (rx_len),
        .field_o    (rx_field),
        .done_o     (rx_done)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        sready_d    = sready_q;
        svalid_d    = svalid_q;
        srdata_d    = srdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wen_d   = 1'b0;
        mem_ren_d   = 1'b0;
        tx_d        = tx_q;
        tx_cnt_d    = tx_cnt_q;

        case (state_q)
            StIdle: begin
                if (mvalid) begin
                    mode_d   = smode;
                    sready_d = 1'b0;
                    state_d  = StAddr;
                end
            end
            StAddr: ;
            StWdata: begin
                if (rx_done) begin
                    mem_wdata_d = rx_field[DATA_WIDTH-1:0];
                    mem_wen_d   = 1'b1;
                    state_d     = StWrite;
                end
            end
            StWrite: begin
                sready_d = 1'b1;
                state_d  = StIdle;
            end
            StRreq: begin
                state_d = StRwait;
            end
            StRwait: begin
                srdata_d = mem_rdata[0];
                tx_d     = mem_rdata >> 1;
                svalid_d = 1'b1;
                tx_cnt_d = TxCntW'(1);
                state_d  = StRdata;
            end
            StRdata: begin
                if (tx_cnt_q == TxCntW'(DATA_WIDTH)) begin
                    svalid_d = 1'b0;
                    srdata_d = 1'b0;
                    sready_d = 1'b1;
                    tx_cnt_d = '0;
                    state_d  = StIdle;
                end else begin
                    srdata_d = tx_q[0];
                    tx_d     = tx_q >> 1;
                    tx_cnt_d = tx_cnt_q + TxCntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Address completion; also covers a one-bit address finishing straight from idle.
        if (rx_done && (state_q == StIdle || state_q == StAddr)) begin
            mem_addr_d = rx_field[ADDR_WIDTH-1:0];
            if (mode_eff == MODE_WRITE) begin
                state_d = StWdata;
            end else begin
                state_d   = StRreq;
                mem_ren_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q     <= StIdle;
            mode_q      <= MODE_READ;
            sready_q    <= 1'b1;
            svalid_q    <= 1'b0;
            srdata_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wen_q   <= 1'b0;
            mem_ren_q   <= 1'b0;
            tx_q        <= '0;
            tx_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            sready_q    <= sready_d;
            svalid_q    <= svalid_d;
            srdata_q    <= srdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wen_q   <= mem_wen_d;
            mem_ren_q   <= mem_ren_d;
            tx_q        <= tx_d;
            tx_cnt_q    <= tx_cnt_d;
        end
    end

    assign sready    = sready_q;
    assign svalid    = svalid_q;
    assign srdata    = srdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wen   = mem_wen_q;
    assign mem_ren   = mem_ren_q;

endmodule

// File: tb/tb_slave_port.sv
// Bench for slave_port: directed frames plus randomised traffic against a memory
// reference model, with exact cycle checks on strobes and serial read data.
module tb_slave_port;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rstn, swdata, smode, mvalid;
    logic          srdata, svalid, sready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wen, mem_ren;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    slave_port #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .swdata    (swdata),
        .smode     (smode),
        .mvalid    (mvalid),
        .srdata    (srdata),
        .svalid    (svalid),
        .sready    (sready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .mem_rdata (mem_rdata)
    );

    // Single-port memory with one cycle of read latency.
    logic [DW-1:0] mem [4096];
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem[mem_addr];
    end

    int cyc = 0, wen_cnt = 0, ren_cnt = 0, wen_cyc = 0, start_cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wen === 1'b1) begin
            wen_cnt <= wen_cnt + 1;
            wen_cyc <= cyc;
        end
        if (mem_ren === 1'b1) ren_cnt <= ren_cnt + 1;
    end

    int checks = 0, errors = 0;
    logic [DW-1:0] ref_mem [int];
    logic [AW-1:0] waddrs [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the last bit's sampling edge.
    task automatic drive_bits(input logic [19:0] bits, input int n, input logic mode,
                              input int stall_after, input int stall_len, input bit gaps);
        for (int i = 0; i < n; i++) begin
            mvalid = 1'b1;
            swdata = bits[i];
            smode  = (i == 0) ? mode : 1'($urandom_range(0, 1));
            if (i == 0) start_cyc = cyc;
            @(posedge clk);
            @(negedge clk);
            if (i == 0) chk("busy_after_first_bit", 32'(sready), 32'd0);
            mvalid = 1'b0;
            swdata = 1'($urandom);
            if (i == stall_after) begin
                repeat (stall_len) @(negedge clk);
            end else if (gaps && i < n - 1 && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int stall_after, input int stall_len, input bit gaps,
                            input string tag, output int lat);
        int w0 = wen_cnt;
        drive_bits({d, a}, AW + DW, 1'b1, stall_after, stall_len, gaps);
        chk($sformatf("%s.wen", tag), 32'(mem_wen), 32'd1);
        chk($sformatf("%s.addr", tag), 32'(mem_addr), 32'(a));
        chk($sformatf("%s.wdata", tag), 32'(mem_wdata), 32'(d));
        chk($sformatf("%s.no_early_wen", tag), 32'(wen_cnt - w0), 32'd0);
        @(negedge clk);
        chk($sformatf("%s.wen_drop", tag), 32'(mem_wen), 32'd0);
        chk($sformatf("%s.sready", tag), 32'(sready), 32'd1);
        chk($sformatf("%s.one_pulse", tag), 32'(wen_cnt - w0), 32'd1);
        lat = wen_cyc - start_cyc;
        ref_mem[int'(a)] = d;
        waddrs.push_back(a);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input bit gaps, input bit inject,
                           input string tag);
        logic [DW-1:0] exp = ref_mem[int'(a)];
        logic [DW-1:0] got = '0;
        int r0 = ren_cnt;
        int w0 = wen_cnt;
        drive_bits({8'h00, a}, AW, 1'b0, -1, 0, gaps);
        chk($sformatf("%s.ren", tag), 32'(mem_ren), 32'd1);
        chk($sformatf("%s.addr", tag), 32'(mem_addr), 32'(a));
        @(negedge clk);
        chk($sformatf("%s.ren_drop", tag), 32'(mem_ren), 32'd0);
        chk($sformatf("%s.svalid_early", tag), 32'(svalid), 32'd0);
        for (int b = 0; b < int'(DW); b++) begin
            @(negedge clk);
            chk($sformatf("%s.svalid[%0d]", tag, b), 32'(svalid), 32'd1);
            chk($sformatf("%s.srdata[%0d]", tag, b), 32'(srdata), 32'(exp[b]));
            got[b] = srdata;
            if (inject) begin
                mvalid = 1'($urandom);
                swdata = 1'($urandom);
                smode  = 1'($urandom);
            end
        end
        @(negedge clk);
        mvalid = 1'b0;
        chk($sformatf("%s.word", tag), 32'(got), 32'(exp));
        chk($sformatf("%s.svalid_end", tag), 32'(svalid), 32'd0);
        chk($sformatf("%s.sready", tag), 32'(sready), 32'd1);
        chk($sformatf("%s.one_ren", tag), 32'(ren_cnt - r0), 32'd1);
        chk($sformatf("%s.no_wen", tag), 32'(wen_cnt - w0), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat0, lat1, w0, r0;
        rstn   = 1'b1;
        mvalid = 1'b0;
        swdata = 1'b0;
        smode  = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        chk("rst.sready", 32'(sready), 32'd1);
        chk("rst.svalid", 32'(svalid), 32'd0);
        chk("rst.srdata", 32'(srdata), 32'd0);
        chk("rst.wen", 32'(mem_wen), 32'd0);
        chk("rst.ren", 32'(mem_ren), 32'd0);
        chk("rst.addr", 32'(mem_addr), 32'd0);
        chk("rst.wdata", 32'(mem_wdata), 32'd0);
        @(negedge clk);

        do_write(12'h5A3, 8'hC7, -1, 0, 1'b0, "wr_nostall", lat0);
        chk("wr_nostall.latency", 32'(lat0), 32'd20);
        do_read(12'h5A3, 1'b0, 1'b0, "rd_5a3");

        // Three idle cycles after the fifth address bit.
        do_write(12'h5A3, 8'hC7, 4, 3, 1'b0, "wr_stall", lat1);
        chk("wr_stall.latency", 32'(lat1), 32'(lat0 + 3));

        // Abort a write frame after six address bits.
        w0 = wen_cnt;
        r0 = ren_cnt;
        drive_bits({8'h3C, 12'h001}, 6, 1'b1, -1, 0, 1'b0);
        rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        chk("abort.sready", 32'(sready), 32'd1);
        chk("abort.addr", 32'(mem_addr), 32'd0);
        repeat (30) @(negedge clk);
        chk("abort.sready_held", 32'(sready), 32'd1);
        chk("abort.no_wen", 32'(wen_cnt - w0), 32'd0);
        chk("abort.no_ren", 32'(ren_cnt - r0), 32'd0);
        do_write(12'h001, 8'h3C, -1, 0, 1'b0, "wr_after_abort", lat0);
        do_read(12'h001, 1'b0, 1'b0, "rd_after_abort");

        // Back-to-back: read starts in the first sready cycle, mvalid noise during RDATA.
        do_write(12'h010, 8'hAA, -1, 0, 1'b0, "wr_b2b", lat0);
        do_read(12'h010, 1'b0, 1'b1, "rd_b2b");

        do_write(12'h000, 8'h00, -1, 0, 1'b0, "wr_lo0", lat0);
        do_write(12'hFFF, 8'hFF, -1, 0, 1'b0, "wr_hiF", lat0);
        do_read(12'h000, 1'b0, 1'b0, "rd_lo0");
        do_read(12'hFFF, 1'b0, 1'b0, "rd_hiF");
        do_write(12'h000, 8'hFF, -1, 0, 1'b0, "wr_loF", lat0);
        do_write(12'hFFF, 8'h00, -1, 0, 1'b0, "wr_hi0", lat0);
        do_read(12'hFFF, 1'b0, 1'b0, "rd_hi0");
        do_read(12'h000, 1'b0, 1'b0, "rd_loF");

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_write(12'($urandom_range(0, 63) * 64 + $urandom_range(0, 3)),
                         8'($urandom), -1, 0, 1'b1, $sformatf("rnd_wr%0d", k), lat0);
            end else begin
                do_read(waddrs[$urandom_range(0, waddrs.size() - 1)], 1'b1,
                        1'($urandom), $sformatf("rnd_rd%0d", k));
            end
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
